// File: rtl/bnn_vector_feeder.sv
`default_nettype none
// ============================================================================
// Module   : bnn_vector_feeder
// Purpose  : Buffers one layer of input neurons from a byte stream, then emits
//            16-lane neuron vectors with their weight words to the BNN datapath
// Revision : 1.0 - initial release
// ============================================================================
module bnn_vector_feeder #(
  parameter int NUM_IN  = 64,
  parameter int NUM_OUT = 8,
  parameter int ADDR_W  = 8,
  parameter int IDX_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wt_rd_en,
  output logic [ADDR_W-1:0]  wt_addr,
  input  logic [15:0]        wt_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0][7:0]   input_neuron,
  output logic [15:0]        weight_bits,
  output logic               out_last,
  output logic [IDX_W-1:0]   out_idx,
  output logic               busy,
  output logic               done
);

  localparam int C_CHUNKS  = NUM_IN / 16;
  localparam int C_BYTE_W  = (NUM_IN > 16) ? $clog2(NUM_IN) : 5;
  localparam int C_CHUNK_W = C_BYTE_W - 4;

  localparam logic [C_BYTE_W-1:0]  C_LAST_BYTE  = C_BYTE_W'(NUM_IN - 1);
  localparam logic [C_CHUNK_W-1:0] C_LAST_CHUNK = C_CHUNK_W'(C_CHUNKS - 1);
  localparam logic [IDX_W-1:0]     C_LAST_IDX   = IDX_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FETCH   = 3'd2,
    S_CAPTURE = 3'd3,
    S_SEND    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state;
  logic [C_BYTE_W-1:0]  r_byte_cnt;
  logic [C_CHUNK_W-1:0] r_chunk;
  logic [7:0]           r_buf [C_CHUNKS][16];

  logic w_last_chunk;
  logic w_last_idx;

  assign w_last_chunk = (r_chunk == C_LAST_CHUNK);
  assign w_last_idx   = (out_idx == C_LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_chunk      <= '0;
      in_ready     <= 1'b0;
      wt_rd_en     <= 1'b0;
      wt_addr      <= '0;
      out_valid    <= 1'b0;
      input_neuron <= '0;
      weight_bits  <= '0;
      out_last     <= 1'b0;
      out_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int c = 0; c < C_CHUNKS; c++) begin
        for (int j = 0; j < 16; j++) begin
          r_buf[c][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_byte_cnt <= '0;
            r_chunk    <= '0;
            out_idx    <= '0;
            wt_addr    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            r_buf[r_byte_cnt[C_BYTE_W-1:4]][r_byte_cnt[3:0]] <= in_data;
            if (r_byte_cnt == C_LAST_BYTE) begin
              r_state  <= S_FETCH;
              in_ready <= 1'b0;
              wt_rd_en <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + C_BYTE_W'(1);
            end
          end
        end

        S_FETCH: begin
          wt_rd_en <= 1'b0;
          r_state  <= S_CAPTURE;
        end

        S_CAPTURE: begin
          weight_bits <= wt_rdata;
          for (int j = 0; j < 16; j++) begin
            input_neuron[j] <= r_buf[r_chunk][j];
          end
          out_last  <= w_last_chunk;
          out_valid <= 1'b1;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (w_last_chunk && w_last_idx) begin
              r_chunk <= '0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Weight words are laid out idx-major, so the next address is always +1
              wt_addr  <= wt_addr + ADDR_W'(1);
              wt_rd_en <= 1'b1;
              r_state  <= S_FETCH;
              if (w_last_chunk) begin
                r_chunk <= '0;
                out_idx <= out_idx + IDX_W'(1);
              end else begin
                r_chunk <= r_chunk + C_CHUNK_W'(1);
              end
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          out_idx <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_vector_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_vector_feeder
// Purpose  : Scoreboard bench for bnn_vector_feeder with directed layer runs
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_vector_feeder;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wt_rd_en;
  logic [7:0]        wt_addr;
  logic [15:0]       wt_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [15:0][7:0]  input_neuron;
  logic [15:0]       weight_bits;
  logic              out_last;
  logic [7:0]        out_idx;
  logic              busy;
  logic              done;

  bnn_vector_feeder #(
    .NUM_IN (64),
    .NUM_OUT(8),
    .ADDR_W (8),
    .IDX_W  (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wt_rd_en    (wt_rd_en),
    .wt_addr     (wt_addr),
    .wt_rdata    (wt_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .input_neuron(input_neuron),
    .weight_bits (weight_bits),
    .out_last    (out_last),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Weight memory model: mem[a] = a * 16'h0101, one-cycle read latency
  always @(posedge clk) begin
    if (wt_rd_en) wt_rdata <= 16'(wt_addr) * 16'h0101;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] neur;
    logic [15:0]  w;
    logic         last;
    logic [7:0]   idx;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  int hs_count, last_hs_cyc, done_cnt, done_cyc;
  int rd_cnt, exp_addr, addr_err, max_addr, first_addr;
  int first_rise, last_rise, spacing_err, acc_cyc;
  bit chk_spacing = 1'b0;
  bit prev_valid  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each handshake plus address/timing bookkeeping
  always @(negedge clk) begin
    if (rst) begin
      if (wt_rd_en) begin
        if (rd_cnt == 0) first_addr = int'(wt_addr);
        if (int'(wt_addr) != exp_addr) addr_err++;
        if (int'(wt_addr) > max_addr) max_addr = int'(wt_addr);
        exp_addr++;
        rd_cnt++;
      end
      if (out_valid && !prev_valid) begin
        if (first_rise < 0) first_rise = cyc;
        if (chk_spacing && last_rise >= 0 && (cyc - last_rise) != 3) spacing_err++;
        last_rise = cyc;
      end
      prev_valid = out_valid;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_vector", 128'(hs_count), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("input_neuron", input_neuron, e.neur);
          chk("weight_bits", weight_bits, e.w);
          chk("out_last", out_last, e.last);
          chk("out_idx", out_idx, e.idx);
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push_expected();
    for (int n = 0; n < 32; n++) begin
      exp_t e;
      e.idx  = 8'(n / 4);
      e.w    = 16'(n) * 16'h0101;
      e.last = ((n % 4) == 3);
      for (int j = 0; j < 16; j++) e.neur[8*j +: 8] = 8'(16 * (n % 4) + j);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input bit sparse, input bit abuse);
    for (int k = 0; k < 64; k++) begin
      int t;
      if (sparse) begin
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        tick();
      end
      in_valid = 1'b1;
      in_data  = 8'(k);
      start    = abuse && (k == 20);
      t = 0;
      while (!in_ready && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) begin
        chk("load_timeout", 128'(k), 128'(64));
        break;
      end
      acc_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic begin_layer(input bit sparse, input bit abuse);
    push_expected();
    hs_count = 0;  done_cnt = 0;   rd_cnt = 0;    exp_addr = 0;
    addr_err = 0;  max_addr = -1;  first_addr = -1;
    first_rise = -1; last_rise = -1; spacing_err = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_bytes(sparse, abuse);
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (hs_count < n && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) chk("wait_hs_timeout", 128'(hs_count), 128'(n));
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("wait_valid_timeout", 128'(out_valid), 128'(1));
  endtask

  task automatic finish_layer(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 1000) begin
      tick();
      t++;
    end
    tick();
    tick();
    chk({tag, "_handshakes"}, 128'(hs_count), 128'(32));
    chk({tag, "_done_pulses"}, 128'(done_cnt), 128'(1));
    chk({tag, "_done_timing"}, 128'(done_cyc), 128'(last_hs_cyc + 1));
    chk({tag, "_rd_count"}, 128'(rd_cnt), 128'(32));
    chk({tag, "_max_addr"}, 128'(max_addr), 128'(31));
    chk({tag, "_addr_order"}, 128'(addr_err), 128'(0));
    chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset with random inputs
    rst       = 1'b0;
    start     = 1'($urandom);
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    out_ready = 1'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wt_rd_en", wt_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_input_neuron", input_neuron, 0);
    chk("rst_weight_bits", weight_bits, 0);
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Test 2: nominal run with back-to-back acceptance
    chk_spacing = 1'b1;
    begin_layer(1'b0, 1'b0);
    finish_layer("nominal");
    chk("nominal_first_latency", 128'(first_rise - acc_cyc), 128'(3));
    chk("nominal_spacing", 128'(spacing_err), 128'(0));
    chk_spacing = 1'b0;
    tick();

    // Test 3: backpressure on vector 5
    begin
      int stall_rd, stall_chg;
      begin_layer(1'b0, 1'b0);
      wait_hs(5);
      out_ready = 1'b0;
      wait_valid();
      chk("bp_lane0", input_neuron[0], 16);
      chk("bp_weight", weight_bits, 16'h0505);
      chk("bp_idx", out_idx, 1);
      stall_rd = 0; stall_chg = 0;
      repeat (5) begin
        tick();
        if (wt_rd_en) stall_rd++;
        if (!out_valid || input_neuron[0] != 8'd16 || weight_bits != 16'h0505 || out_idx != 8'd1)
          stall_chg++;
      end
      chk("bp_stall_reads", 128'(stall_rd), 128'(0));
      chk("bp_stall_changes", 128'(stall_chg), 128'(0));
      chk("bp_hs_during_stall", 128'(hs_count), 128'(5));
      out_ready = 1'b1;
      finish_layer("backpressure");
    end
    tick();

    // Tests 4/5: sparse load with start abuse, then SEND-state abuse
    begin
      int rdy_seen;
      begin_layer(1'b1, 1'b1);
      wait_hs(2);
      out_ready = 1'b0;
      wait_valid();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      rdy_seen = 0;
      repeat (3) begin
        tick();
        start = 1'b0;
        if (in_ready) rdy_seen++;
      end
      in_valid = 1'b0;
      chk("abuse_in_ready_send", 128'(rdy_seen), 128'(0));
      chk("abuse_busy_send", busy, 1);
      out_ready = 1'b1;
      finish_layer("sparse");
    end
    tick();

    // Test 6: reset while vector 10 is presented, then a fresh layer
    begin_layer(1'b0, 1'b0);
    wait_hs(10);
    out_ready = 1'b0;
    wait_valid();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_input_neuron", input_neuron, 0);
    chk("midrst_weight_bits", weight_bits, 0);
    chk("midrst_out_idx", out_idx, 0);
    sb.delete();
    tick();
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    begin_layer(1'b0, 1'b0);
    finish_layer("restart");
    chk("restart_first_addr", 128'(first_addr), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
